// File: rtl/fb_sprite_blitter.sv
// Sprite blitter: copies a w x h sprite from a synchronous ROM into the
// downscaled framebuffer with edge clipping and colour-key transparency.
module fb_sprite_blitter #(
  parameter int HSIZE   = 160,
  parameter int VSIZE   = 120,
  parameter int AWIDTH  = 15,
  parameter int CWIDTH  = 12,
  parameter int SWIDTH  = 8,
  parameter int SAWIDTH = 14,
  parameter int DWIDTH  = 12,
  parameter logic [DWIDTH-1:0] TRANSP = 12'h000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [CWIDTH-1:0]  x0,
  input  logic signed [CWIDTH-1:0]  y0,
  input  logic [SWIDTH-1:0]         w,
  input  logic [SWIDTH-1:0]         h,
  input  logic [SAWIDTH-1:0]        src_base,
  output logic [SAWIDTH-1:0]        src_addr,
  input  logic [DWIDTH-1:0]         src_data,
  output logic                      fb_we,
  output logic [AWIDTH-1:0]         fb_addr,
  output logic [DWIDTH-1:0]         fb_data,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  localparam logic signed [CWIDTH:0] HMAX =
    (CWIDTH+1)'(HSIZE - 1);
  localparam logic signed [CWIDTH:0] VMAX =
    (CWIDTH+1)'(VSIZE - 1);

  state_t state_q, state_d;

  logic signed [CWIDTH-1:0] x0_q, x0_d;
  logic signed [CWIDTH-1:0] y0_q, y0_d;
  logic [SWIDTH-1:0]  w_q, w_d;
  logic [SWIDTH-1:0]  h_q, h_d;
  logic [SWIDTH-1:0]  i_q, i_d;
  logic [SWIDTH-1:0]  j_q, j_d;
  logic [SAWIDTH-1:0] ptr_q, ptr_d;

  logic              v1_q;
  logic              vis1_q;
  logic [AWIDTH-1:0] addr1_q;

  logic              we_q;
  logic [AWIDTH-1:0] fb_addr_q;
  logic [DWIDTH-1:0] fb_data_q;

  logic                    issue;
  logic                    i_last;
  logic                    j_last;
  logic signed [CWIDTH:0]  px;
  logic signed [CWIDTH:0]  py;
  logic                    vis;
  logic [AWIDTH-1:0]       addr;

  assign i_last = (i_q == w_q - SWIDTH'(1));
  assign j_last = (j_q == h_q - SWIDTH'(1));

  // One extra bit so x0+i never overflows before the range test.
  assign px = $signed({x0_q[CWIDTH-1], x0_q})
            + $signed({{(CWIDTH+1-SWIDTH){1'b0}}, i_q});
  assign py = $signed({y0_q[CWIDTH-1], y0_q})
            + $signed({{(CWIDTH+1-SWIDTH){1'b0}}, j_q});

  assign vis = !px[CWIDTH] && (px <= HMAX)
            && !py[CWIDTH] && (py <= VMAX);

  assign addr = AWIDTH'(py) * AWIDTH'(HSIZE)
              + AWIDTH'(px);

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    i_d     = i_q;
    j_d     = j_q;
    ptr_d   = ptr_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w != '0 && h != '0) begin
            x0_d    = x0;
            y0_d    = y0;
            w_d     = w;
            h_d     = h;
            i_d     = '0;
            j_d     = '0;
            ptr_d   = src_base;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        issue = 1'b1;
        ptr_d = ptr_q + SAWIDTH'(1);
        if (i_last) begin
          i_d = '0;
          j_d = j_q + SWIDTH'(1);
          if (j_last) state_d = S_DRAIN1;
        end else begin
          i_d = i_q + SWIDTH'(1);
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ptr_q   <= ptr_d;
    end
  end

  // Address/visibility travel one stage to line up with src_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      vis1_q    <= 1'b0;
      addr1_q   <= '0;
      we_q      <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      v1_q   <= issue;
      vis1_q <= issue & vis;
      if (issue) addr1_q <= addr;
      we_q <= v1_q & vis1_q & (src_data != TRANSP);
      if (v1_q) begin
        fb_addr_q <= addr1_q;
        fb_data_q <= src_data;
      end
    end
  end

  assign src_addr = ptr_q;
  assign fb_we    = we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign busy     = (state_q == S_RUN)
                 || (state_q == S_DRAIN1)
                 || (state_q == S_DRAIN2);
  assign done     = (state_q == S_DONE);

endmodule

// File: doc/fb_sprite_blitter.md
Name: fb_sprite_blitter

Overview:
Writer side of the downscaled framebuffer. On a start pulse it copies a w×h sprite from a synchronous source ROM into the framebuffer at a signed (x0, y0) position in framebuffer pixels. It produces the same row-major address layout the display read path consumes: addr = y*HSIZE + x. Off-screen pixels are clipped and transparent pixels are skipped. Sits between game logic (sprite placement) and the framebuffer BRAM write port.

Parameters:
HSIZE, 160, framebuffer width in pixels (640 / 2^IWIDTH, IWIDTH=2)
VSIZE, 120, framebuffer height in pixels
AWIDTH, 15, framebuffer address width
CWIDTH, 12, signed width of x0/y0
SWIDTH, 8, width of sprite w/h
SAWIDTH, 14, source ROM address width
DWIDTH, 12, pixel data width (RGB444)
TRANSP, 12'h000, transparent colour key

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
x0  in  CWIDTH signed  sprite left column in framebuffer pixels
y0  in  CWIDTH signed  sprite top row in framebuffer pixels
w  in  SWIDTH  sprite width
h  in  SWIDTH  sprite height
src_base  in  SAWIDTH  ROM address of sprite pixel (0,0); sprite stored row-major, stride w
src_addr  out  SAWIDTH  ROM read address
src_data  in  DWIDTH  ROM data, valid the cycle after src_addr
fb_we  out  1  framebuffer write enable
fb_addr  out  AWIDTH  framebuffer write address
fb_data  out  DWIDTH  framebuffer write data
busy  out  1  blit in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. busy, done, fb_we = 0. fb_addr, fb_data, src_addr = 0. Reset mid-blit aborts immediately: no further writes and no done.
- States: IDLE, RUN, DRAIN1, DRAIN2, DONE.
- IDLE: start=1 with w≠0 and h≠0 latches x0, y0, w, h, src_base; clears column i and row j; sets src_ptr=src_base; goes to RUN.
- IDLE: start=1 with w=0 or h=0 goes to DONE, with no writes and busy held low.
- RUN: each cycle presents src_addr=src_ptr for pixel (i,j), then increments src_ptr and i. When i=w-1, i wraps to 0 and j increments. After pixel (w-1,h-1) the state goes to DRAIN1. RUN lasts exactly w*h cycles.
- DRAIN1 → DRAIN2 → DONE → IDLE. done=1 only in DONE.
- busy=1 in RUN, DRAIN1, DRAIN2.
- start asserted outside IDLE is ignored; it is not queued.
- Pipeline: a pixel issued in cycle c has src_data in cycle c+1 and its write slot in cycle c+2. Write slots are contiguous, one per pixel.
- Coordinates: px = x0+i and py = y0+j, computed in CWIDTH+1 signed. The pixel is visible iff 0≤px≤HSIZE-1 and 0≤py≤VSIZE-1.
- Address: fb_addr = py*HSIZE + px, truncated to AWIDTH. The address and visible flag are registered alongside the ROM latency so they align with src_data.
- Write enable: fb_we=1 in a write slot iff the pixel is visible and src_data≠TRANSP. fb_addr and fb_data update every write slot regardless of fb_we.
- Timing from the start edge (cycle 0 = the cycle start is sampled): RUN spans cycles 1..w*h, write slots span cycles 3..w*h+2, done pulses in cycle w*h+3. A new start is accepted from cycle w*h+4.
- Input params may change freely after the start cycle; latched values are used.

Test Plan:
- Basic: x0=10, y0=5, w=2, h=2, src_base=0, ROM[a]=a+1 → src_addr 0,1,2,3 in cycles 1–4; fb_we in cycles 3–6 with (addr,data)=(810,1),(811,2),(970,3),(971,4); done in cycle 7 only; busy high in cycles 1–6.
- Top/left clip: x0=-1, y0=-1, w=2, h=2 → only one write, fb_addr=0 with data ROM[3], in cycle 6; done still in cycle 7.
- Bottom/right clip: x0=159, y0=119, w=2, h=2 → single write at fb_addr=19199 in cycle 3; no address wrap writes.
- Transparency: 3×1 sprite with ROM data {0x0F0, 0x000, 0xF00} at x0=0, y0=0 → writes to addr 0 and 2 only; fb_we low in the middle slot.
- Degenerate and ignore: w=0 → done in cycle 1, busy never high, no writes. A start pulse during a 4×4 blit → ignored, exactly 16 write slots and one done.
- Reset mid-run: assert rst in cycle 3 of a 4×4 blit → next cycle fb_we=0, busy=0; done never pulses; a later start behaves as the Basic case.
